// File: rtl/padctrl_pkg.sv
// padctrl_pkg: register map and CTRL field layout for padctrl_bank.
// Shared with the software header generator, so addresses must stay stable.
package padctrl_pkg;

    localparam int BUS_AW = 4;
    localparam int BUS_DW = 32;

    localparam logic [3:0] ADDR_CTRL       = 4'd0;
    localparam logic [3:0] ADDR_PU         = 4'd1;
    localparam logic [3:0] ADDR_PD         = 4'd2;
    localparam logic [3:0] ADDR_KEEP       = 4'd3;
    localparam logic [3:0] ADDR_IN         = 4'd4;
    localparam logic [3:0] ADDR_RISE_EN    = 4'd5;
    localparam logic [3:0] ADDR_FALL_EN    = 4'd6;
    localparam logic [3:0] ADDR_IRQ_STATUS = 4'd7;
    localparam logic [3:0] ADDR_STATUS     = 4'd8;

    localparam int CTRL_SCHMITT_BIT    = 0;
    localparam int CTRL_SLEW_BIT       = 1;
    localparam int CTRL_DRIVE_LSB      = 2;
    localparam int CTRL_DRIVE_MSB      = 3;
    localparam int STATUS_RELEASED_BIT = 0;

    // Member order matches the CTRL bit positions above (schmitt is bit 0).
    typedef struct packed {
        logic [1:0] drive;
        logic       slew;
        logic       schmitt;
    } ctrl_t;

endpackage

// File: rtl/padctrl_bank_if.sv
// padctrl_bank_if: simple register bus into padctrl_bank (single-cycle strobes, registered read data).
interface padctrl_bank_if;
    import padctrl_pkg::*;

    logic [BUS_AW-1:0] addr;
    logic              wen;
    logic              ren;
    logic [BUS_DW-1:0] wdata;
    logic [BUS_DW-1:0] rdata;

    modport master (output addr, output wen, output ren, output wdata, input  rdata);
    modport slave  (input  addr, input  wen, input  ren, input  wdata, output rdata);

endinterface

// File: rtl/padctrl_sync.sv
// padctrl_sync: WIDTH-bit, STAGES-deep synchroniser for asynchronous pad inputs.
module padctrl_sync #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [STAGES-1:0][WIDTH-1:0] stage_d;

    assign stage_d = {stage_q[STAGES-2:0], d};
    assign q       = stage_q[STAGES-1];

    // NOTE: every stage is reset, not just the last, so no stale pad value can
    // ripple out onto q during the first cycles after reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so all stages sample their old neighbour on the same edge.
        if (rst) stage_q <= '0;
        else     stage_q <= stage_d;
    end

endmodule

// File: rtl/padctrl_bank.sv
// padctrl_bank: register-configured controller for a row of bidirectional pads with
// sequenced output release, pull/keeper control, input synchronisers and edge interrupts.
module padctrl_bank
    import padctrl_pkg::*;
#(
    parameter int                N_PADS        = 16,
    parameter int                SYNC_STAGES   = 2,
    parameter int                RELEASE_DELAY = 16,
    parameter logic [N_PADS-1:0] PU_RESET      = '0,
    parameter logic [N_PADS-1:0] PD_RESET      = '1,
    parameter logic [N_PADS-1:0] KEEP_RESET    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_PADS-1:0] core_out,
    input  logic [N_PADS-1:0] core_oe,
    output logic [N_PADS-1:0] sync_in,
    input  logic [N_PADS-1:0] padin,
    output logic [N_PADS-1:0] padout,
    output logic [N_PADS-1:0] padoe,
    output logic [N_PADS-1:0] pad_ie,
    output logic [N_PADS-1:0] pad_pu,
    output logic [N_PADS-1:0] pad_pd,
    output logic              pad_schmitt,
    output logic              pad_slew,
    output logic [1:0]        pad_drive,
    output logic              enable_fixed_outputs,
    padctrl_bank_if.slave     bus,
    output logic              irq
);

    localparam int CNT_W = $clog2(RELEASE_DELAY + 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [N_PADS-1:0] pu_q, pu_d, pd_q, pd_d, keep_en_q, keep_en_d;
    logic [N_PADS-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [N_PADS-1:0] irq_status_q, irq_status_d;
    logic [N_PADS-1:0] keep_q, keep_d, prev_q, prev_d;
    logic [31:0]       rdata_q, rdata_d, rd_mux;
    logic [N_PADS-1:0] wdata_n, rise, fall, irq_set;
    logic              released;
    logic              unused_wdata;

    padctrl_sync #(
        .WIDTH  (N_PADS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (padin),
        .q   (sync_in)
    );

    assign released             = (cnt_q == CNT_W'(RELEASE_DELAY));
    assign enable_fixed_outputs = released;
    assign cnt_d                = released ? cnt_q : cnt_q + CNT_W'(1);

    assign padout      = core_out;
    assign padoe       = core_oe & {N_PADS{released}};
    assign pad_ie      = ~padoe;
    assign pad_schmitt = ctrl_q.schmitt;
    assign pad_slew    = ctrl_q.slew;
    assign pad_drive   = ctrl_q.drive;

    // Before release, KEEP acts as an extra pull-down so undriven pads sit low.
    always_comb begin
        pad_pu = '0;
        pad_pd = '0;
        if (released) begin
            pad_pu = (keep_en_q & keep_q) | (~keep_en_q & pu_q & ~pd_q);
            pad_pd = (keep_en_q & ~keep_q) | (~keep_en_q & pd_q);
        end else begin
            pad_pu = pu_q & ~pd_q & ~keep_en_q;
            pad_pd = pd_q | keep_en_q;
        end
    end

    assign keep_d  = (padoe & padout) | (~padoe & sync_in);
    assign prev_d  = sync_in;
    assign rise    = sync_in & ~prev_q;
    assign fall    = ~sync_in & prev_q;
    assign irq_set = ((rise & rise_en_q) | (fall & fall_en_q)) & {N_PADS{released}};
    assign irq     = |irq_status_q;

    assign wdata_n      = bus.wdata[N_PADS-1:0];
    assign unused_wdata = ^bus.wdata;

    always_comb begin
        // NOTE: every next-state value gets a hold default first, so no path infers a latch.
        ctrl_d       = ctrl_q;
        pu_d         = pu_q;
        pd_d         = pd_q;
        keep_en_d    = keep_en_q;
        rise_en_d    = rise_en_q;
        fall_en_d    = fall_en_q;
        irq_status_d = irq_status_q;
        if (bus.wen) begin
            case (bus.addr)
                ADDR_CTRL:       ctrl_d       = ctrl_t'(bus.wdata[CTRL_DRIVE_MSB:0]);
                ADDR_PU:         pu_d         = wdata_n;
                ADDR_PD:         pd_d         = wdata_n;
                ADDR_KEEP:       keep_en_d    = wdata_n;
                ADDR_RISE_EN:    rise_en_d    = wdata_n;
                ADDR_FALL_EN:    fall_en_d    = wdata_n;
                ADDR_IRQ_STATUS: irq_status_d = irq_status_q & ~wdata_n;
                default:         ;
            endcase
        end
        // Applied after the clear so a fresh edge survives a same-cycle W1C.
        irq_status_d = irq_status_d | irq_set;
    end

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            ADDR_CTRL:       rd_mux = 32'(ctrl_q);
            ADDR_PU:         rd_mux = 32'(pu_q);
            ADDR_PD:         rd_mux = 32'(pd_q);
            ADDR_KEEP:       rd_mux = 32'(keep_en_q);
            ADDR_IN:         rd_mux = 32'(sync_in);
            ADDR_RISE_EN:    rd_mux = 32'(rise_en_q);
            ADDR_FALL_EN:    rd_mux = 32'(fall_en_q);
            ADDR_IRQ_STATUS: rd_mux = 32'(irq_status_q);
            ADDR_STATUS:     rd_mux[STATUS_RELEASED_BIT] = released;
            default:         rd_mux = '0;
        endcase
    end

    assign rdata_d   = bus.ren ? rd_mux : rdata_q;
    assign bus.rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            ctrl_q       <= '0;
            pu_q         <= PU_RESET;
            pd_q         <= PD_RESET;
            keep_en_q    <= KEEP_RESET;
            rise_en_q    <= '0;
            fall_en_q    <= '0;
            irq_status_q <= '0;
            keep_q       <= '0;
            prev_q       <= '0;
            rdata_q      <= '0;
        end else begin
            cnt_q        <= cnt_d;
            ctrl_q       <= ctrl_d;
            pu_q         <= pu_d;
            pd_q         <= pd_d;
            keep_en_q    <= keep_en_d;
            rise_en_q    <= rise_en_d;
            fall_en_q    <= fall_en_d;
            irq_status_q <= irq_status_d;
            keep_q       <= keep_d;
            prev_q       <= prev_d;
            rdata_q      <= rdata_d;
        end
    end

endmodule

// File: tb/tb_padctrl_bank.sv
// tb_padctrl_bank: directed + random stimulus; a behavioural model predicts every cycle's
// outputs into a scoreboard queue that a negedge monitor pops and compares.
module tb_padctrl_bank;
    import padctrl_pkg::*;

    localparam int N_PADS        = 16;
    localparam int SYNC_STAGES   = 2;
    localparam int RELEASE_DELAY = 16;

    typedef logic [N_PADS-1:0] pad_t;

    localparam pad_t PU_RST   = '0;
    localparam pad_t PD_RST   = '1;
    localparam pad_t KEEP_RST = '0;

    typedef struct {
        pad_t        padout, padoe, pad_ie, pad_pu, pad_pd, sync_in;
        logic        schmitt, slew, efo, irq;
        logic [1:0]  drive;
        logic [31:0] rdata;
    } exp_t;

    logic clk, rst;
    pad_t core_out, core_oe, padin;
    pad_t sync_in, padout, padoe, pad_ie, pad_pu, pad_pd;
    logic pad_schmitt, pad_slew, enable_fixed_outputs, irq;
    logic [1:0] pad_drive;

    padctrl_bank_if bus_if ();

    padctrl_bank #(
        .N_PADS        (N_PADS),
        .SYNC_STAGES   (SYNC_STAGES),
        .RELEASE_DELAY (RELEASE_DELAY),
        .PU_RESET      (PU_RST),
        .PD_RESET      (PD_RST),
        .KEEP_RESET    (KEEP_RST)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .core_out             (core_out),
        .core_oe              (core_oe),
        .sync_in              (sync_in),
        .padin                (padin),
        .padout               (padout),
        .padoe                (padoe),
        .pad_ie               (pad_ie),
        .pad_pu               (pad_pu),
        .pad_pd               (pad_pd),
        .pad_schmitt          (pad_schmitt),
        .pad_slew             (pad_slew),
        .pad_drive            (pad_drive),
        .enable_fixed_outputs (enable_fixed_outputs),
        .bus                  (bus_if),
        .irq                  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    // Staged inputs: applied to the pins at the start of the next step().
    logic        s_rst, s_wen, s_ren;
    pad_t        s_core_out, s_core_oe, s_padin;
    logic [3:0]  s_addr;
    logic [31:0] s_wdata;

    // Reference model state, in register-map terms.
    int          m_cycles;
    logic [3:0]  m_ctrl;
    pad_t        m_pu, m_pd, m_keep, m_rise, m_fall, m_irq, m_keeper, m_prev;
    logic [31:0] m_rdata;
    pad_t        m_pin_hist[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] read_reg(input logic [3:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            4'd0: r[3:0]       = m_ctrl;
            4'd1: r[N_PADS-1:0] = m_pu;
            4'd2: r[N_PADS-1:0] = m_pd;
            4'd3: r[N_PADS-1:0] = m_keep;
            4'd4: r[N_PADS-1:0] = m_pin_hist[0];
            4'd5: r[N_PADS-1:0] = m_rise;
            4'd6: r[N_PADS-1:0] = m_fall;
            4'd7: r[N_PADS-1:0] = m_irq;
            4'd8: r[0]          = (m_cycles >= RELEASE_DELAY);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Advance the model across one rising edge, using the inputs held during the cycle just ended.
    function automatic void model_edge();
        logic released;
        pad_t sync, oe, set;
        if (rst) begin
            m_cycles = 0;
            m_ctrl = '0; m_pu = PU_RST; m_pd = PD_RST; m_keep = KEEP_RST;
            m_rise = '0; m_fall = '0; m_irq = '0; m_keeper = '0; m_prev = '0; m_rdata = '0;
            m_pin_hist = {};
            for (int i = 0; i < SYNC_STAGES; i++) m_pin_hist.push_back('0);
            return;
        end
        released = (m_cycles >= RELEASE_DELAY);
        sync     = m_pin_hist[0];
        oe       = released ? core_oe : '0;
        if (bus_if.ren) m_rdata = read_reg(bus_if.addr);
        set = '0;
        for (int i = 0; i < N_PADS; i++) begin
            m_keeper[i] = oe[i] ? core_out[i] : sync[i];
            if (released && m_rise[i] && sync[i] && !m_prev[i]) set[i] = 1'b1;
            if (released && m_fall[i] && !sync[i] && m_prev[i]) set[i] = 1'b1;
        end
        if (bus_if.wen) begin
            case (bus_if.addr)
                4'd0: m_ctrl = bus_if.wdata[3:0];
                4'd1: m_pu   = bus_if.wdata[N_PADS-1:0];
                4'd2: m_pd   = bus_if.wdata[N_PADS-1:0];
                4'd3: m_keep = bus_if.wdata[N_PADS-1:0];
                4'd5: m_rise = bus_if.wdata[N_PADS-1:0];
                4'd6: m_fall = bus_if.wdata[N_PADS-1:0];
                4'd7: m_irq  = m_irq & ~bus_if.wdata[N_PADS-1:0];
                default: ;
            endcase
        end
        m_irq  = m_irq | set;
        m_prev = sync;
        m_pin_hist.push_back(padin);
        void'(m_pin_hist.pop_front());
        if (m_cycles < RELEASE_DELAY) m_cycles++;
    endfunction

    function automatic exp_t model_outputs();
        exp_t e;
        logic released;
        released  = (m_cycles >= RELEASE_DELAY);
        e.padout  = core_out;
        e.padoe   = released ? core_oe : '0;
        e.pad_ie  = ~e.padoe;
        e.sync_in = m_pin_hist[0];
        for (int i = 0; i < N_PADS; i++) begin
            if (!released) begin
                e.pad_pd[i] = m_pd[i] | m_keep[i];
                e.pad_pu[i] = m_pu[i] & ~m_pd[i] & ~m_keep[i];
            end else if (m_keep[i]) begin
                e.pad_pu[i] = m_keeper[i];
                e.pad_pd[i] = ~m_keeper[i];
            end else if (m_pu[i] && m_pd[i]) begin
                e.pad_pu[i] = 1'b0;
                e.pad_pd[i] = 1'b1;
            end else begin
                e.pad_pu[i] = m_pu[i];
                e.pad_pd[i] = m_pd[i];
            end
        end
        e.schmitt = m_ctrl[0];
        e.slew    = m_ctrl[1];
        e.drive   = m_ctrl[3:2];
        e.efo     = released;
        e.irq     = (m_irq != '0);
        e.rdata   = m_rdata;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        rst          = s_rst;
        core_out     = s_core_out;
        core_oe      = s_core_oe;
        padin        = s_padin;
        bus_if.addr  = s_addr;
        bus_if.wen   = s_wen;
        bus_if.ren   = s_ren;
        bus_if.wdata = s_wdata;
        sb_q.push_back(model_outputs());
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        s_addr = a; s_wdata = d; s_wen = 1'b1;
        step();
        s_wen = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a);
        s_addr = a; s_ren = 1'b1;
        step();
        s_ren = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("padout",  32'(padout),  32'(e.padout));
            check("padoe",   32'(padoe),   32'(e.padoe));
            check("pad_ie",  32'(pad_ie),  32'(e.pad_ie));
            check("pad_pu",  32'(pad_pu),  32'(e.pad_pu));
            check("pad_pd",  32'(pad_pd),  32'(e.pad_pd));
            check("sync_in", 32'(sync_in), 32'(e.sync_in));
            check("ctrl",    32'({pad_drive, pad_slew, pad_schmitt}), 32'({e.drive, e.slew, e.schmitt}));
            check("release", 32'(enable_fixed_outputs), 32'(e.efo));
            check("irq",     32'(irq),     32'(e.irq));
            check("rdata",   bus_if.rdata, e.rdata);
        end
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected run completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        rst = 1'b1; core_out = '0; core_oe = '1; padin = '0;
        bus_if.addr = '0; bus_if.wen = 1'b0; bus_if.ren = 1'b0; bus_if.wdata = '0;
        s_rst = 1'b1; s_core_out = '0; s_core_oe = '1; s_padin = '0;
        s_addr = '0; s_wen = 1'b0; s_ren = 1'b0; s_wdata = '0;

        // Reset and output release with every OE requested.
        repeat (3) step();
        s_rst = 1'b0;
        repeat (20) step();
        bus_read(ADDR_STATUS);
        step();

        // Keeper: drive pad 0 high, then stop driving with the pin held high, then let it fall.
        bus_write(ADDR_PD, 32'h0);
        bus_write(ADDR_KEEP, 32'h1);
        s_core_oe = '0; s_core_out = pad_t'(1); s_core_oe[0] = 1'b1; s_padin[0] = 1'b1;
        repeat (3) step();
        s_core_oe[0] = 1'b0;
        repeat (4) step();
        s_padin[0] = 1'b0;
        repeat (4) step();

        // PU and PD both set, keeper off.
        bus_write(ADDR_KEEP, 32'h0);
        bus_write(ADDR_PU, 32'h3);
        bus_write(ADDR_PD, 32'h3);
        repeat (2) step();

        // Rising-edge interrupt on pad 2, then clear it.
        bus_write(ADDR_RISE_EN, 32'h4);
        s_padin[2] = 1'b1;
        repeat (4) step();
        bus_read(ADDR_IRQ_STATUS);
        bus_write(ADDR_IRQ_STATUS, 32'h4);
        repeat (2) step();

        // New rise on pad 2 landing in the same cycle as its W1C.
        s_padin[2] = 1'b0;
        repeat (4) step();
        s_padin[2] = 1'b1;
        repeat (2) step();
        bus_write(ADDR_IRQ_STATUS, 32'h4);
        bus_read(ADDR_IRQ_STATUS);
        step();

        // Random traffic across the whole map, including unused addresses.
        for (int i = 0; i < 1500; i++) begin
            s_core_out = pad_t'($urandom);
            s_core_oe  = pad_t'($urandom);
            if ($urandom_range(2) == 0) s_padin = s_padin ^ (pad_t'(1) << $urandom_range(N_PADS - 1));
            s_wen   = ($urandom_range(4) == 0);
            s_ren   = ($urandom_range(2) == 0);
            s_addr  = 4'($urandom_range(15));
            s_wdata = $urandom;
            step();
        end
        s_wen = 1'b0; s_ren = 1'b0;

        // One-cycle reset mid-traffic, then re-release.
        s_core_oe = '1;
        s_rst = 1'b1;
        step();
        s_rst = 1'b0;
        repeat (20) step();
        for (int r = 0; r < 9; r++) bus_read(4'(r));
        step();

        for (int i = 0; i < 300; i++) begin
            s_core_out = pad_t'($urandom);
            s_core_oe  = pad_t'($urandom);
            s_padin    = pad_t'($urandom);
            s_wen   = ($urandom_range(3) == 0);
            s_ren   = ($urandom_range(1) == 0);
            s_addr  = 4'($urandom_range(15));
            s_wdata = $urandom;
            step();
        end
        s_wen = 1'b0; s_ren = 1'b0;
        step();

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
